// File: rtl/cpu_pkg.sv
// Shared CPU-wide constants and the fetch-entry type carried from fetch into IF/ID.
package cpu_pkg;

    localparam int              PC_W        = 8;
    localparam int              INSTR_W     = 19;
    localparam int              FETCH_DEPTH = 4;
    localparam logic [PC_W-1:0] RESET_PC    = 8'h00;

    typedef struct packed {
        logic [INSTR_W-1:0] instruction;
        logic [PC_W-1:0]    pc_plus_one;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: synchronous FIFO with flush; pointers carry one extra wrap bit.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 27
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic [WIDTH-1:0]           head_data_o
);
    localparam int IDX_W = $clog2(DEPTH);

    logic [IDX_W:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push_s, do_pop_s;

    assign count_o     = wr_ptr_q - rd_ptr_q;
    assign do_pop_s    = pop_i && (count_o != '0);
    // A full queue may still accept a push when the head leaves in the same cycle.
    assign do_push_s   = push_i && ((count_o != (IDX_W+1)'(DEPTH)) || do_pop_s);
    assign head_data_o = mem_q[rd_ptr_q[IDX_W-1:0]];

    // Pointer next state; flush empties the queue and wins over push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            rd_ptr_d = wr_ptr_q;
        end else begin
            if (do_push_s) wr_ptr_d = wr_ptr_q + (IDX_W+1)'(1);
            else           wr_ptr_d = wr_ptr_q;
            if (do_pop_s)  rd_ptr_d = rd_ptr_q + (IDX_W+1)'(1);
            else           rd_ptr_d = rd_ptr_q;
        end
    end

    // Pointer registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Entry storage, cleared on reset so the head reads zero.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (do_push_s && !flush_i) begin
            mem_q[wr_ptr_q[IDX_W-1:0]] <= push_data_i;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited in-order requests to variable-latency memory,
// a prefetch queue toward decode, and redirect flush with stale-response dropping.
module fetch_unit #(
    parameter int DEPTH   = cpu_pkg::FETCH_DEPTH,
    parameter int PC_W    = cpu_pkg::PC_W,
    parameter int INSTR_W = cpu_pkg::INSTR_W
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               id_valid,
    input  logic               id_ready,
    output logic [INSTR_W-1:0] id_instruction,
    output logic [PC_W-1:0]    id_pc_plus_one
);
    import cpu_pkg::*;

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int ENT_W = INSTR_W + PC_W;

    logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0] outst_q, outst_d, drop_q, drop_d, count_s;
    logic [CNT_W:0]   inflight_s;
    logic             credit_s, issue_s, push_s, pop_s;
    logic [ENT_W-1:0] push_data_s, head_data_s;

    // Queued plus in-flight never exceeds DEPTH, so every response has a slot.
    assign inflight_s = {1'b0, outst_q} + {1'b0, count_s};
    assign credit_s   = inflight_s < (CNT_W+1)'(DEPTH);
    assign issue_s    = !reset && !redirect && credit_s;
    assign imem_req   = issue_s;
    assign imem_addr  = fetch_pc_q;

    assign id_valid       = (count_s != '0);
    assign pop_s          = id_valid && id_ready && !redirect;
    assign push_s         = imem_rvalid && (drop_q == '0) && !redirect;
    assign push_data_s    = {imem_rdata, resp_pc_q + PC_W'(1)};
    assign id_instruction = head_data_s[ENT_W-1:PC_W];
    assign id_pc_plus_one = head_data_s[PC_W-1:0];

    // PC, credit and drop bookkeeping; redirect takes priority over everything.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        outst_d    = outst_q;
        drop_d     = drop_q;
        if (redirect) begin
            fetch_pc_d = redirect_pc;
            resp_pc_d  = redirect_pc;
            outst_d    = outst_q - CNT_W'(imem_rvalid);
            drop_d     = outst_d;
        end else begin
            if (issue_s) fetch_pc_d = fetch_pc_q + PC_W'(1);
            else         fetch_pc_d = fetch_pc_q;
            outst_d = outst_q + CNT_W'(issue_s) - CNT_W'(imem_rvalid);
            if (imem_rvalid && (drop_q != '0)) drop_d = drop_q - CNT_W'(1);
            else                               drop_d = drop_q;
            if (push_s) resp_pc_d = resp_pc_q + PC_W'(1);
            else        resp_pc_d = resp_pc_q;
        end
    end

    // Fetch state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= PC_W'(RESET_PC);
            resp_pc_q  <= PC_W'(RESET_PC);
            outst_q    <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk_i       (clk),
        .reset_i     (reset),
        .flush_i     (redirect),
        .push_i      (push_s),
        .push_data_i (push_data_s),
        .pop_i       (pop_s),
        .count_o     (count_s),
        .head_data_o (head_data_s)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a fixed-latency in-order memory model.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_rvalid;
    logic [18:0] imem_rdata;
    logic        redirect;
    logic [7:0]  redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [18:0] id_instruction;
    logic [7:0]  id_pc_plus_one;

    int          n_assert;
    int          n_fail;
    int          cyc;
    int          lat;
    logic [7:0]  pend_addr [$];
    int          pend_due  [$];

    fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instruction (id_instruction),
        .id_pc_plus_one (id_pc_plus_one)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [18:0] mk(input logic [7:0] a);
        return {3'b101, a, ~a};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_resp();
        if (pend_due.size() > 0 && pend_due[0] == cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mk(pend_addr[0]);
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 19'h0;
        end
    endtask

    task automatic step();
        #1;
        if (imem_req === 1'b1) begin
            pend_addr.push_back(imem_addr);
            pend_due.push_back(cyc + lat);
        end
        @(posedge clk);
        #1;
        cyc++;
        set_resp();
        #1;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        redirect    = 1'b0;
        id_ready    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 19'h0;
        pend_addr.delete();
        pend_due.delete();
        step();
        step();
        reset = 1'b0;
        cyc   = 0;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_assert = 0; n_fail = 0; cyc = 0; lat = 1;
        reset = 1'b0; redirect = 1'b0; redirect_pc = 8'h00; id_ready = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = 19'h0;
        #1 reset = 1'b1;
        #1;
        chk("rst_req",   imem_req,       32'd0);
        chk("rst_valid", id_valid,       32'd0);
        chk("rst_instr", id_instruction, 32'd0);
        chk("rst_pc1",   id_pc_plus_one, 32'd0);
        do_reset();

        // Fill with decode stalled: four back-to-back requests, then credit runs out.
        for (int i = 0; i < 4; i++) begin
            chk("fill_req",  imem_req,  32'd1);
            chk("fill_addr", imem_addr, 32'(i));
            if (i >= 2) begin
                chk("fill_valid", id_valid,       32'd1);
                chk("fill_pc1",   id_pc_plus_one, 32'd1);
            end
            step();
        end
        chk("full_req",   imem_req,       32'd0);
        chk("full_valid", id_valid,       32'd1);
        chk("hold_pc1",   id_pc_plus_one, 32'd1);
        chk("hold_instr", id_instruction, 32'(mk(8'h00)));
        step();
        chk("full_req2",   imem_req,       32'd0);
        chk("hold_pc1_2",  id_pc_plus_one, 32'd1);
        chk("hold_instr2", id_instruction, 32'(mk(8'h00)));

        // Streaming with decode always ready.
        id_ready = 1'b1;
        #1;
        for (int i = 0; i < 8; i++) begin
            chk("strm_valid", id_valid,       32'd1);
            chk("strm_pc1",   id_pc_plus_one, 32'(i + 1));
            chk("strm_instr", id_instruction, 32'(mk(8'(i))));
            if (i >= 1) begin
                chk("strm_req",  imem_req,  32'd1);
                chk("strm_addr", imem_addr, 32'(i + 3));
            end
            step();
        end

        // Redirect with two stale requests in flight on a 3-cycle memory.
        do_reset();
        lat = 3; id_ready = 1'b1;
        step();
        step();
        redirect = 1'b1; redirect_pc = 8'h40;
        #1;
        chk("rd1_req", imem_req, 32'd0);
        step();
        redirect = 1'b0;
        #1;
        chk("rd1_req_nx", imem_req,  32'd1);
        chk("rd1_addr",   imem_addr, 32'h40);
        chk("rd1_v3",     id_valid,  32'd0);
        step();
        chk("rd1_addr2", imem_addr, 32'h41);
        chk("rd1_v4",    id_valid,  32'd0);
        step();
        chk("rd1_v5", id_valid, 32'd0);
        step();
        chk("rd1_v6", id_valid, 32'd0);
        step();
        chk("rd1_v7",     id_valid,       32'd1);
        chk("rd1_pc1",    id_pc_plus_one, 32'h41);
        chk("rd1_instr",  id_instruction, 32'(mk(8'h40)));

        // Redirect near the top of the address space: fetch wraps to 0.
        do_reset();
        lat = 1; id_ready = 1'b1;
        redirect = 1'b1; redirect_pc = 8'hFE;
        #1;
        chk("wr_req0", imem_req, 32'd0);
        step();
        redirect = 1'b0;
        #1;
        chk("wr_addr_fe", imem_addr, 32'hFE);
        step();
        chk("wr_addr_ff", imem_addr, 32'hFF);
        step();
        chk("wr_addr_00", imem_addr,      32'h00);
        chk("wr_v",       id_valid,       32'd1);
        chk("wr_pc_ff",   id_pc_plus_one, 32'hFF);
        chk("wr_i_fe",    id_instruction, 32'(mk(8'hFE)));
        step();
        chk("wr_pc_00", id_pc_plus_one, 32'h00);
        chk("wr_i_ff",  id_instruction, 32'(mk(8'hFF)));
        step();
        chk("wr_pc_01", id_pc_plus_one, 32'h01);
        chk("wr_i_00",  id_instruction, 32'(mk(8'h00)));

        // Redirect coinciding with a response and a pending pop.
        redirect = 1'b1; redirect_pc = 8'h80;
        #1;
        chk("rv_req0", imem_req, 32'd0);
        step();
        redirect = 1'b0;
        #1;
        chk("rv_valid", id_valid,  32'd0);
        chk("rv_req",   imem_req,  32'd1);
        chk("rv_addr",  imem_addr, 32'h80);
        step();
        chk("rv_valid2", id_valid, 32'd0);
        step();
        chk("rv_valid3", id_valid,       32'd1);
        chk("rv_pc1",    id_pc_plus_one, 32'h81);
        chk("rv_instr",  id_instruction, 32'(mk(8'h80)));

        // Reset with three entries queued and one request outstanding.
        id_ready = 1'b0;
        step();
        step();
        chk("mr_valid_pre", id_valid,       32'd1);
        chk("mr_req_pre",   imem_req,       32'd0);
        chk("mr_pc1_pre",   id_pc_plus_one, 32'h81);
        reset = 1'b1;
        #1;
        chk("mr_valid", id_valid,       32'd0);
        chk("mr_req",   imem_req,       32'd0);
        chk("mr_pc1",   id_pc_plus_one, 32'd0);
        chk("mr_instr", id_instruction, 32'd0);
        imem_rvalid = 1'b0; imem_rdata = 19'h0;
        pend_addr.delete();
        pend_due.delete();
        step();
        reset = 1'b0;
        cyc   = 0;
        #1;
        chk("mr_req0",  imem_req,  32'd1);
        chk("mr_addr0", imem_addr, 32'h00);
        step();
        chk("mr_addr1", imem_addr, 32'h01);
        step();
        chk("mr_valid2", id_valid,       32'd1);
        chk("mr_pc1_2",  id_pc_plus_one, 32'h01);
        chk("mr_instr2", id_instruction, 32'(mk(8'h00)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
